// File: rtl/bram_word_sequencer.sv
// bram_word_sequencer
// Block-RAM pattern store and playback engine. It feeds parallel words to the
// 8:1 OSERDES2 master/slave pair on the fabric clock. Patterns are written
// through a simple write port. A start pulse then plays them out once or in a
// continuous loop. While idle the word output is all-zeros, so the serial line
// stays low.
//
// Ports
//   clock          fabric clock (PLL x1 output); all logic on the rising edge
//   reset          asynchronous, active-low reset
//   write_enable   write write_data to write_address on this edge
//   write_address  memory write address
//   write_data     memory write data
//   start          begin playback; only honoured while idle
//   stop           abort playback
//   loop_mode      1 = wrap forever, 0 = one-shot; latched at start
//   last_address   final address of the pattern; latched at start
//   word           registered parallel word to the serializer, MSB first out
//   busy           playback in progress
//   done           one-cycle pulse when playback ends
//   loop_count     completed wraps in the current/last run, saturating
module bram_word_sequencer #(
   parameter int WIDTH            = 8,
   parameter int ADDR_WIDTH       = 10,
   parameter int LOOP_COUNT_WIDTH = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        write_enable,
   input  logic [ADDR_WIDTH-1:0]       write_address,
   input  logic [WIDTH-1:0]            write_data,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        loop_mode,
   input  logic [ADDR_WIDTH-1:0]       last_address,
   output logic [WIDTH-1:0]            word,
   output logic                        busy,
   output logic                        done,
   output logic [LOOP_COUNT_WIDTH-1:0] loop_count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {IDLE, PLAY} state_t;

   logic [WIDTH-1:0]            mem_q [DEPTH];
   logic [WIDTH-1:0]            rdData_q;

   state_t                      state_q;
   logic [WIDTH-1:0]            word_q;
   logic                        busy_q;
   logic                        done_q;
   logic [LOOP_COUNT_WIDTH-1:0] loopCount_q;
   logic [ADDR_WIDTH-1:0]       rdAddr_q;
   logic [ADDR_WIDTH-1:0]       lastAddr_q;
   logic                        loopMode_q;
   logic                        issuing_q;
   logic                        rdValid_q;
   logic                        rdLast_q;
   logic                        wordLast_q;
   logic                        atLast;

   assign atLast = (rdAddr_q == lastAddr_q);

   // Simple dual-port BRAM with no reset, so the contents survive a reset.
   // The read port reads every cycle from the playback address. Both ports
   // use non-blocking assignments in one block. On a same-address collision
   // the read therefore returns the old word (read-first behaviour).
   always_ff @(posedge clock) begin
      if (write_enable) begin
         mem_q[write_address] <= write_data;
      end
      rdData_q <= mem_q[rdAddr_q];
   end

   // Playback control and the registered outputs. Each word passes through a
   // three-stage pipeline:
   //   issue  - rdAddr_q
   //   read   - rdData_q, rdValid_q, rdLast_q
   //   output - word_q, wordLast_q
   // In one-shot mode, issuing stops after the last address is read. The run
   // ends one cycle after that last word has been presented. A stop request
   // ends the run at once and discards anything still in the pipeline.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         word_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         loopCount_q <= '0;
         rdAddr_q    <= '0;
         lastAddr_q  <= '0;
         loopMode_q  <= 1'b0;
         issuing_q   <= 1'b0;
         rdValid_q   <= 1'b0;
         rdLast_q    <= 1'b0;
         wordLast_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               word_q     <= '0;
               busy_q     <= 1'b0;
               rdValid_q  <= 1'b0;
               rdLast_q   <= 1'b0;
               wordLast_q <= 1'b0;
               if (start && !stop) begin
                  lastAddr_q  <= last_address;
                  loopMode_q  <= loop_mode;
                  rdAddr_q    <= '0;
                  loopCount_q <= '0;
                  issuing_q   <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= PLAY;
               end
            end
            PLAY: begin
               if (stop || wordLast_q) begin
                  state_q    <= IDLE;
                  word_q     <= '0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  issuing_q  <= 1'b0;
                  rdValid_q  <= 1'b0;
                  rdLast_q   <= 1'b0;
                  wordLast_q <= 1'b0;
                  rdAddr_q   <= '0;
               end else begin
                  word_q     <= rdValid_q ? rdData_q : '0;
                  wordLast_q <= rdLast_q;
                  rdValid_q  <= issuing_q;
                  rdLast_q   <= issuing_q && atLast && !loopMode_q;
                  if (issuing_q) begin
                     if (atLast) begin
                        rdAddr_q <= '0;
                        if (loopMode_q) begin
                           if (loopCount_q != '1) begin
                              loopCount_q <= loopCount_q + 1'b1;
                           end
                        end else begin
                           issuing_q <= 1'b0;
                        end
                     end else begin
                        rdAddr_q <= rdAddr_q + 1'b1;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign word       = word_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign loop_count = loopCount_q;

endmodule

// File: tb/tb_bram_word_sequencer.sv
// tb_bram_word_sequencer
// Directed bench for bram_word_sequencer using the default parameters.
// Inputs change and outputs are sampled on the falling clock edge. Every value
// therefore reflects the most recent rising edge. Expected values are written
// out by hand from the intended timing:
//   - the edge that samples start makes busy go high;
//   - mem[k] appears two edges later plus k;
//   - the edge that samples stop, or the edge after the last one-shot word,
//     clears word and busy and raises done.
module tb_bram_word_sequencer;

   logic        clock;
   logic        reset;
   logic        writeEnable;
   logic [9:0]  writeAddress;
   logic [7:0]  writeData;
   logic        start;
   logic        stop;
   logic        loopMode;
   logic [9:0]  lastAddress;
   logic [7:0]  word;
   logic        busy;
   logic        done;
   logic [15:0] loopCount;

   int checkCount;
   int failCount;

   logic [7:0] pattern [4];

   bram_word_sequencer dut (
      .clock         (clock),
      .reset         (reset),
      .write_enable  (writeEnable),
      .write_address (writeAddress),
      .write_data    (writeData),
      .start         (start),
      .stop          (stop),
      .loop_mode     (loopMode),
      .last_address  (lastAddress),
      .word          (word),
      .busy          (busy),
      .done          (done),
      .loop_count    (loopCount)
   );

   // 10-unit clock period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Safety net in case the bench stops advancing.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it when the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advances through one rising edge and returns at the next falling edge.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic writeMem(input logic [9:0] addr, input logic [7:0] data);
      writeEnable  = 1'b1;
      writeAddress = addr;
      writeData    = data;
      tick();
      writeEnable  = 1'b0;
   endtask

   // Presents start for exactly one rising edge (edge N) and returns after it.
   task automatic applyStimulus(input logic [9:0] last, input logic loopIn);
      lastAddress = last;
      loopMode    = loopIn;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic stopRun();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      checkCount   = 0;
      failCount    = 0;
      reset        = 1'b0;
      writeEnable  = 1'b0;
      writeAddress = '0;
      writeData    = '0;
      start        = 1'b0;
      stop         = 1'b0;
      loopMode     = 1'b0;
      lastAddress  = '0;
      pattern[0] = 8'h01;
      pattern[1] = 8'h03;
      pattern[2] = 8'h07;
      pattern[3] = 8'h0F;

      // Reset state.
      tick();
      tick();
      checkOutput("rst_word", 32'(word), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_done", 32'(done), 32'h0);
      checkOutput("rst_loop", 32'(loopCount), 32'h0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) writeMem(10'(i), pattern[i]);

      // One-shot playback of four words.
      applyStimulus(10'd3, 1'b0);
      checkOutput("os_busyN", 32'(busy), 32'h1);
      checkOutput("os_wordN", 32'(word), 32'h0);
      tick();
      checkOutput("os_wordN1", 32'(word), 32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput("os_word", 32'(word), 32'(pattern[k]));
         checkOutput("os_busy", 32'(busy), 32'h1);
         checkOutput("os_done0", 32'(done), 32'h0);
      end
      tick();
      checkOutput("os_wordEnd", 32'(word), 32'h0);
      checkOutput("os_doneEnd", 32'(done), 32'h1);
      checkOutput("os_busyEnd", 32'(busy), 32'h0);
      tick();
      checkOutput("os_donePulse", 32'(done), 32'h0);

      // Looped playback, then stop.
      applyStimulus(10'd3, 1'b1);
      tick();
      for (int k = 0; k < 10; k++) begin
         tick();
         checkOutput("lp_word", 32'(word), 32'(pattern[k % 4]));
      end
      checkOutput("lp_count2", 32'(loopCount), 32'd2);
      stopRun();
      checkOutput("lp_stopWord", 32'(word), 32'h0);
      checkOutput("lp_stopDone", 32'(done), 32'h1);
      checkOutput("lp_stopBusy", 32'(busy), 32'h0);
      checkOutput("lp_stopCount", 32'(loopCount), 32'd2);
      tick();
      checkOutput("lp_doneLow", 32'(done), 32'h0);
      checkOutput("lp_countHold", 32'(loopCount), 32'd2);

      // Single-word pattern, one-shot.
      writeMem(10'd0, 8'hA5);
      applyStimulus(10'd0, 1'b0);
      tick();
      tick();
      checkOutput("sw_word", 32'(word), 32'hA5);
      checkOutput("sw_busy", 32'(busy), 32'h1);
      tick();
      checkOutput("sw_wordEnd", 32'(word), 32'h0);
      checkOutput("sw_done", 32'(done), 32'h1);
      checkOutput("sw_busyEnd", 32'(busy), 32'h0);

      // Single-word pattern, looped until loop_count saturates.
      applyStimulus(10'd0, 1'b1);
      tick();
      checkOutput("swl_count1", 32'(loopCount), 32'd1);
      tick();
      checkOutput("swl_word", 32'(word), 32'hA5);
      checkOutput("swl_count2", 32'(loopCount), 32'd2);
      tick();
      checkOutput("swl_count3", 32'(loopCount), 32'd3);
      repeat (65540) @(posedge clock);
      @(negedge clock);
      checkOutput("swl_sat", 32'(loopCount), 32'hFFFF);
      checkOutput("swl_satWord", 32'(word), 32'hA5);
      stopRun();
      checkOutput("swl_stopDone", 32'(done), 32'h1);
      checkOutput("swl_stopCount", 32'(loopCount), 32'hFFFF);

      // A start pulse during playback must not disturb the sequence.
      writeMem(10'd0, 8'h01);
      applyStimulus(10'd3, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         start = (k == 1);
         tick();
         checkOutput("sp_word", 32'(word), 32'(pattern[k]));
      end
      start = 1'b0;
      tick();
      checkOutput("sp_done", 32'(done), 32'h1);
      checkOutput("sp_busy", 32'(busy), 32'h0);

      // Start and stop together while idle: stop wins.
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      checkOutput("ss_busy", 32'(busy), 32'h0);
      checkOutput("ss_word", 32'(word), 32'h0);
      checkOutput("ss_done", 32'(done), 32'h0);
      tick();
      checkOutput("ss_busy2", 32'(busy), 32'h0);
      checkOutput("ss_done2", 32'(done), 32'h0);

      // Overwrite mem[2] on the same edge that reads it during a loop.
      applyStimulus(10'd3, 1'b1);
      tick();
      tick();
      checkOutput("wc_w0", 32'(word), 32'h01);
      writeEnable  = 1'b1;
      writeAddress = 10'd2;
      writeData    = 8'h55;
      tick();
      writeEnable  = 1'b0;
      checkOutput("wc_w1", 32'(word), 32'h03);
      tick();
      checkOutput("wc_old", 32'(word), 32'h07);
      tick();
      tick();
      tick();
      checkOutput("wc_w1b", 32'(word), 32'h03);
      tick();
      checkOutput("wc_new", 32'(word), 32'h55);
      stopRun();

      // Asynchronous reset between edges during looped playback.
      applyStimulus(10'd3, 1'b1);
      repeat (6) tick();
      checkOutput("ar_countPre", 32'(loopCount), 32'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("ar_word", 32'(word), 32'h0);
      checkOutput("ar_busy", 32'(busy), 32'h0);
      checkOutput("ar_count", 32'(loopCount), 32'h0);
      #1 reset = 1'b1;
      @(negedge clock);
      checkOutput("ar_idleBusy", 32'(busy), 32'h0);
      applyStimulus(10'd3, 1'b0);
      tick();
      tick();
      checkOutput("ar_m0", 32'(word), 32'h01);
      tick();
      checkOutput("ar_m1", 32'(word), 32'h03);
      tick();
      checkOutput("ar_m2", 32'(word), 32'h55);
      tick();
      checkOutput("ar_m3", 32'(word), 32'h0F);
      tick();
      checkOutput("ar_done", 32'(done), 32'h1);

      $display("test done: total=%0d bad=%0d", checkCount, failCount);
      $finish;
   end

endmodule
